// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state type and address field helpers for the cache
package cache_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int INDEX_W = 2;
  localparam int OFFSET_W = 2;
  localparam int BYTE_W = 2;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;
  localparam int BLOCK_W = 4 * DATA_W;
  localparam int BLK_ADDR_W = TAG_W + INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[BYTE_W+OFFSET_W +: INDEX_W];
  endfunction
  function automatic logic [OFFSET_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[BYTE_W +: OFFSET_W];
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/dirty/tag/data storage; async read by rd_idx, sync word write (sets dirty), block fill (tag/valid, clears dirty), dirty clear
module cache_line_array
  import cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_line,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                clr_en,
  input  logic [INDEX_W-1:0]  clr_idx
);
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [BLOCK_W-1:0] data_d [LINES];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_line = data_q[rd_idx];
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d = tag_q;
    data_d = data_q;
    if (wr_en) begin
      data_d[wr_idx][wr_word*DATA_W +: DATA_W] = wr_data;
      dirty_d[wr_idx] = 1'b1;
    end
    if (fill_en) begin
      data_d[fill_idx] = fill_data;
      tag_d[fill_idx] = fill_tag;
      valid_d[fill_idx] = 1'b1;
      dirty_d[fill_idx] = 1'b0;
    end
    if (clr_en) dirty_d[clr_idx] = 1'b0;
  end
  always_ff @(posedge clock) begin
    valid_q <= reset ? '0 : valid_d;
    dirty_q <= reset ? '0 : dirty_d;
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-back cache; CPU read/write/Address/Write_Data -> rData/hit, block port mem_read/mem_write/mem_block_addr/mem_wdata <- mem_rdata/mem_ready
module cache_controller
  import cache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [DATA_W-1:0]     Write_Data,
  output logic [DATA_W-1:0]     rData,
  output logic                  hit,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BLK_ADDR_W-1:0] mem_block_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
);
  state_t state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d, idx, rd_idx;
  logic [BLK_ADDR_W-1:0] victim_q, victim_d, req_q, req_d;
  logic [TAG_W-1:0] tag, rd_tag;
  logic rd_valid, rd_dirty, req;
  logic [BLOCK_W-1:0] rd_line;
  assign idx = addr_idx(Address);
  assign tag = addr_tag(Address);
  assign rd_idx = state_q == COMPARE ? idx : idx_q;
  cache_line_array u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (hit & write),
    .wr_idx    (idx),
    .wr_word   (addr_word(Address)),
    .wr_data   (Write_Data),
    .fill_en   (mem_read & mem_ready),
    .fill_idx  (idx_q),
    .fill_tag  (req_q[INDEX_W +: TAG_W]),
    .fill_data (mem_rdata),
    .clr_en    (mem_write & mem_ready),
    .clr_idx   (idx_q)
  );
  always_comb begin
    req = read | write;
    hit = state_q == COMPARE && req && rd_valid && rd_tag == tag;
    rData = hit && read ? rd_line[addr_word(Address)*DATA_W +: DATA_W] : '0;
    mem_write = state_q == WRITEBACK;
    mem_read = state_q == ALLOCATE;
    mem_block_addr = mem_write ? victim_q : mem_read ? req_q : '0;
    mem_wdata = mem_write ? rd_line : '0;
    state_d = state_q;
    idx_d = idx_q;
    victim_d = victim_q;
    req_d = req_q;
    if (state_q == COMPARE && req && !hit) begin
      idx_d = idx;
      victim_d = {rd_tag, idx};
      req_d = {tag, idx};
      state_d = rd_valid && rd_dirty ? WRITEBACK : ALLOCATE;
    end
    if (mem_write && mem_ready) state_d = ALLOCATE;
    if (mem_read && mem_ready) state_d = COMPARE;
  end
  always_ff @(posedge clock) begin
    state_q <= reset ? COMPARE : state_d;
    idx_q <= idx_d;
    victim_q <= victim_d;
    req_q <= req_d;
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench with a 2-cycle block memory and an architectural reference model
module tb_cache_controller;
  typedef struct packed {logic [5:0] a; logic [127:0] d;} wb_t;
  logic clock = 0, reset = 1, read = 0, write = 0, hit, mem_read, mem_write, mem_ready = 0;
  logic [9:0] Address = 0;
  logic [31:0] Write_Data = 0, rData;
  logic [5:0] mem_block_addr;
  logic [127:0] mem_wdata, mem_rdata = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  bit m_valid [4];
  bit m_dirty [4];
  logic [3:0] m_tag [4];
  logic [31:0] exp_rd [$];
  logic [5:0] exp_fill [$];
  wb_t exp_wb [$];
  int n_chk = 0, n_pass = 0, n_hit = 0, n_wb = 0, n_wb_exp = 0, cnt = 0;
  int seq_w [10] = '{24, 20, 16, 12, 58, 51, 52, 59, 46, 17};
  int seq_d [10] = '{0, 0, 123, 234, 345, 456, 0, 0, 567, 678};
  cache_controller dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .Address(Address),
    .Write_Data(Write_Data), .rData(rData), .hit(hit), .mem_read(mem_read),
    .mem_write(mem_write), .mem_block_addr(mem_block_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clock) begin
    #2;
    mem_ready = 0;
    if (reset || !(mem_read || mem_write)) cnt = 0;
    else begin
      cnt++;
      if (cnt == 2) begin
        cnt = 0;
        mem_ready = 1;
        for (int k = 0; k < 4; k++)
          if (mem_write) mem[int'(mem_block_addr)*4+k] = mem_wdata[k*32 +: 32];
          else mem_rdata[k*32 +: 32] = mem[int'(mem_block_addr)*4+k];
      end
    end
  end
  always @(negedge clock) begin
    if (hit) begin
      n_hit++;
      if (read && !write) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rdata", rData, exp_rd.pop_front());
      end
    end
    if (mem_read || mem_write) chk("mem_excl", {mem_read, mem_write, hit}, mem_read ? 3'b100 : 3'b010);
    if (mem_read) begin
      if (exp_fill.size() == 0) chk("fill_unexpected", 1, 0);
      else begin
        chk("fill_addr", mem_block_addr, exp_fill[0]);
        if (mem_ready) void'(exp_fill.pop_front());
      end
    end
    if (mem_write) begin
      if (exp_wb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        chk("wb_addr", mem_block_addr, exp_wb[0].a);
        chk("wb_data", mem_wdata, exp_wb[0].d);
        if (mem_ready) begin
          void'(exp_wb.pop_front());
          n_wb++;
        end
      end
    end
  end
  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int w = 0; w < 256; w++) ref_mem[w] = mem[w];
    exp_rd.delete();
    exp_fill.delete();
    exp_wb.delete();
  endtask
  task automatic model(input logic [9:0] a, input bit wr, input bit push_rd, input logic [31:0] d, output int lat);
    int i = int'(a[5:4]);
    int w = int'(a[9:2]);
    logic [3:0] t = a[9:6];
    wb_t e;
    lat = 0;
    if (!(m_valid[i] && m_tag[i] == t)) begin
      lat = 3;
      if (m_valid[i] && m_dirty[i]) begin
        e.a = {m_tag[i], a[5:4]};
        for (int k = 0; k < 4; k++) e.d[k*32 +: 32] = ref_mem[int'(e.a)*4+k];
        exp_wb.push_back(e);
        n_wb_exp++;
        lat = 5;
      end
      exp_fill.push_back(a[9:4]);
      m_valid[i] = 1;
      m_tag[i] = t;
      m_dirty[i] = 0;
    end
    if (wr) begin
      ref_mem[w] = d;
      m_dirty[i] = 1;
    end else if (push_rd) exp_rd.push_back(ref_mem[w]);
  endtask
  task automatic cpu(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
    int lat = 0, el;
    model(a, wr, rd, d, el);
    read = rd;
    write = wr;
    Address = a;
    Write_Data = d;
    @(negedge clock);
    while (!hit && lat < 40) begin
      lat++;
      @(negedge clock);
    end
    chk($sformatf("latency_%0h", a), lat, el);
    @(posedge clock);
    #1;
    read = 0;
    write = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    read = 0;
    write = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    clear_model();
  endtask
  task automatic wait_mem_read(input bit level);
    int n = 0;
    @(negedge clock);
    while (mem_read != level && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("mem_read_wait", mem_read, level);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int h0, w0, e0, el;
    for (int w = 0; w < 256; w++) mem[w] = w;
    do_reset();
    @(negedge clock);
    chk("rst_hit", hit, 0);
    chk("rst_mem_rw", {mem_read, mem_write}, 0);
    chk("rst_addr", mem_block_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rData, 0);
    @(posedge clock);
    #1;
    cpu(1, 0, 10'h060, 0);
    cpu(0, 1, 10'h040, 123);
    cpu(0, 1, 10'h0CC, 456);
    for (int k = 0; k < 4; k++) cpu(1, 0, 10'(12'h0C0 + k*4), 0);
    cpu(0, 1, 10'h0E8, 345);
    cpu(1, 0, 10'h0ED, 0);
    do_reset();
    h0 = n_hit;
    w0 = n_wb;
    e0 = n_wb_exp;
    for (int s = 0; s < 10; s++) cpu(seq_d[s] == 0, seq_d[s] != 0, 10'(seq_w[s]*4), seq_d[s]);
    chk("seq_hits", n_hit - h0, 10);
    chk("seq_writebacks", n_wb - w0, n_wb_exp - e0);
    for (int k = 0; k < 4; k++) cpu(1, 0, 10'(12'h040 + k*4), 0);
    model(10'h100, 0, 1, 0, el);
    read = 1;
    Address = 10'h100;
    wait_mem_read(1);
    @(posedge clock);
    #1;
    reset = 1;
    read = 0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_hit", hit, 0);
    @(posedge clock);
    #1 reset = 0;
    clear_model();
    cpu(1, 0, 10'h100, 0);
    cpu(1, 1, 10'h104, 999);
    cpu(1, 0, 10'h104, 0);
    cpu(1, 0, 10'h000, 0);
    model(10'h010, 0, 0, 0, el);
    read = 1;
    Address = 10'h010;
    wait_mem_read(1);
    @(posedge clock);
    #1 read = 0;
    h0 = n_hit;
    wait_mem_read(0);
    chk("drop_no_hit", n_hit - h0, 0);
    @(posedge clock);
    #1;
    cpu(1, 0, 10'h014, 0);
    repeat (2) @(posedge clock);
    chk("rd_left", exp_rd.size(), 0);
    chk("fill_left", exp_fill.size(), 0);
    chk("wb_left", exp_wb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
